param_alu: RTL and testbench

//  Parametrised multi-cycle ALU: next generation of the 8-bit start/done ALU.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mul_pipe.sv | 39 +++
 rtl/param_alu.sv | 176 +++++++++++++++++
 tb/tb_param_alu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for param_alu: opcode encoding and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    nop_op = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    sub_op = 3'b101
  } operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_mul_pipe.sv
// Registered unsigned multiplier: MUL_LAT-1 register stages, combinational when MUL_LAT==1.
// flush_i synchronously clears every stage.
module alu_mul_pipe #(
  parameter int DATA_W  = 8,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [2*DATA_W-1:0] p_o
);

  localparam int STAGES = MUL_LAT - 1;

  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

  generate
    if (STAGES == 0) begin : g_comb
      assign p_o = prod;
    end else begin : g_pipe
      logic [2*DATA_W-1:0] stage_q [STAGES];

      // Stage 0 reloads every cycle; the controller's counter picks the right slot.
      always_ff @(posedge clk) begin
        if (flush_i) begin
          for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= prod;
          for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign p_o = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/param_alu.sv
// Multi-cycle ALU behind a level start / pulse done handshake.
// Optional macro ALU_FLAGS_EN adds registered zero/carry/ovf outputs.
//
// state | meaning
// IDLE  | waiting for start; operands and opcode taken on the edge leaving here
// EXEC  | multiply in flight, counter runs down to completion
// HOLD  | result delivered, waiting for start to drop
module param_alu
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [2:0]          op,
  input  logic                start,
  output logic                done,
  output logic                busy,
`ifdef ALU_FLAGS_EN
  output logic                zero,
  output logic                carry,
  output logic                ovf,
`endif
  output logic [2*DATA_W-1:0] result
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  alu_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                flush;
  logic [2*DATA_W-1:0] mul_p;
  logic [2*DATA_W-1:0] a_ext, b_ext, sum, diff;
  logic [2*DATA_W-1:0] single_res;
  logic                single_op;
  operation_t          op_t;

  assign op_t  = operation_t'(op);
  assign a_ext = {{DATA_W{1'b0}}, A};
  assign b_ext = {{DATA_W{1'b0}}, B};
  assign sum   = a_ext + b_ext;
  assign diff  = a_ext - b_ext;

  always_comb begin
    single_res = '0;
    single_op  = 1'b1;
    case (op_t)
      add_op:  single_res = sum;
      and_op:  single_res = a_ext & b_ext;
      xor_op:  single_res = a_ext ^ b_ext;
      sub_op:  single_res = diff;
      default: single_op  = 1'b0;
    endcase
  end

  alu_mul_pipe #(
    .DATA_W (DATA_W),
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clk    (clk),
    .flush_i(flush),
    .a_i    (A),
    .b_i    (B),
    .p_o    (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    flush    = rst;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (single_op) begin
            result_d = single_res;
            done_d   = 1'b1;
            state_d  = HOLD;
          end else if (op_t == mul_op) begin
            if (MUL_LAT == 1) begin
              result_d = mul_p;
              done_d   = 1'b1;
              state_d  = HOLD;
            end else begin
              cnt_d   = CNT_W'(MUL_LAT - 1);
              state_d = EXEC;
            end
          end
        end
      end
      EXEC: begin
        if (!start) begin
          flush   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          result_d = mul_p;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign busy   = (state_q == EXEC) || (state_q == HOLD);
  assign result = result_q;

`ifdef ALU_FLAGS_EN
  logic zero_q, carry_q, ovf_q;
  logic carry_d, ovf_d;

  // Overflow is judged on the DATA_W-bit signed view of the operands.
  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    if (state_q == IDLE) begin
      case (op_t)
        add_op: begin
          carry_d = sum[DATA_W];
          ovf_d   = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
        end
        sub_op: begin
          carry_d = (A < B);
          ovf_d   = (A[DATA_W-1] != B[DATA_W-1]) && (diff[DATA_W-1] != A[DATA_W-1]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (done_d) begin
      zero_q  <= (result_d == '0);
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu (DATA_W=8, MUL_LAT=3); flag checks only with ALU_FLAGS_EN.
module tb_param_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_s, b_s;
  logic [2:0]  op_s;
  logic        start_s;
  logic        done_s, busy_s;
  logic [15:0] result_s;
`ifdef ALU_FLAGS_EN
  logic        zero_s, carry_s, ovf_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_done;

  localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, AND = 3'b010,
                         XOR = 3'b011, MUL = 3'b100, SUB = 3'b101;

  always #5 clk = ~clk;

  param_alu #(.DATA_W(8), .MUL_LAT(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (a_s),
    .B     (b_s),
    .op    (op_s),
    .start (start_s),
    .done  (done_s),
    .busy  (busy_s),
`ifdef ALU_FLAGS_EN
    .zero  (zero_s),
    .carry (carry_s),
    .ovf   (ovf_s),
`endif
    .result(result_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; signals are then sampled/driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op_s = o; a_s = a; b_s = b; start_s = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start_s = 1'b0; op_s = NOP; a_s = '0; b_s = '0;
    step(); step();
    chk("rst_done", done_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_result", result_s, 16'h0000);
    rst = 1'b0;
    step();

    // ADD with carry out
    go(ADD, 8'hFF, 8'h01);
    step();
    chk("add_done", done_s, 1);
    chk("add_result", result_s, 16'h0100);
    chk("add_busy", busy_s, 1);
`ifdef ALU_FLAGS_EN
    chk("add_carry", carry_s, 1);
    chk("add_zero", zero_s, 0);
`endif
    step();
    chk("add_done_pulse", done_s, 0);
    start_s = 1'b0;
    step();
    chk("add_idle_busy", busy_s, 0);

    // MUL: done only at capture+3, operand changes after capture ignored
    go(MUL, 8'hFF, 8'hFF);
    step();
    chk("mul_c1_done", done_s, 0);
    chk("mul_c1_busy", busy_s, 1);
    a_s = 8'h00; b_s = 8'h00;
    step();
    chk("mul_c2_done", done_s, 0);
    step();
    chk("mul_c3_done", done_s, 1);
    chk("mul_result", result_s, 16'hFE01);
    step();
    chk("mul_c4_done", done_s, 0);
    start_s = 1'b0;
    step();

    // SUB with borrow
    go(SUB, 8'h03, 8'h05);
    step();
    chk("sub_done", done_s, 1);
    chk("sub_result", result_s, 16'hFFFE);
`ifdef ALU_FLAGS_EN
    chk("sub_carry", carry_s, 1);
    chk("sub_ovf", ovf_s, 0);
`endif
    start_s = 1'b0;
    step();

    // XOR to zero
    go(XOR, 8'hAA, 8'hAA);
    step();
    chk("xor_done", done_s, 1);
    chk("xor_result", result_s, 16'h0000);
`ifdef ALU_FLAGS_EN
    chk("xor_zero", zero_s, 1);
    chk("xor_carry", carry_s, 0);
`endif
    start_s = 1'b0;
    step();

`ifdef ALU_FLAGS_EN
    // Signed overflow: 0x7F + 0x01
    go(ADD, 8'h7F, 8'h01);
    step();
    chk("ovf_result", result_s, 16'h0080);
    chk("ovf_flag", ovf_s, 1);
    start_s = 1'b0;
    step();
`endif

    // AND with start held 5 cycles past done: exactly one done
    go(AND, 8'hF0, 8'h3C);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done_s) n_done++;
    end
    chk("hold_single_done", n_done, 1);
    chk("and_result", result_s, 16'h0030);
    chk("hold_busy", busy_s, 1);
    start_s = 1'b0;
    step();

    // NOP: no done, result held, stays idle
    go(NOP, 8'h12, 8'h34);
    step();
    chk("nop_done", done_s, 0);
    chk("nop_busy", busy_s, 0);
    start_s = 1'b0;
    step();
    chk("nop_result", result_s, 16'h0030);

    // Opcode 111 behaves as NOP
    go(3'b111, 8'h12, 8'h34);
    step();
    chk("rsv_done", done_s, 0);
    chk("rsv_busy", busy_s, 0);
    start_s = 1'b0;
    step();

    // MUL with reset asserted in cycle capture+2
    go(MUL, 8'h02, 8'h03);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mulrst_done", done_s, 0);
    chk("mulrst_result", result_s, 16'h0000);
    chk("mulrst_busy", busy_s, 0);
    rst = 1'b0; start_s = 1'b0;
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done_s) n_done++;
    end
    chk("mulrst_no_done", n_done, 0);

    // Known result, then abort a MUL by dropping start
    go(ADD, 8'h01, 8'h02);
    step();
    chk("pre_abort_result", result_s, 16'h0003);
    start_s = 1'b0;
    step();
    go(MUL, 8'h04, 8'h05);
    step();
    start_s = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done_s) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_result", result_s, 16'h0003);
    chk("abort_busy", busy_s, 0);

    // MUL after an abort still completes on time
    go(MUL, 8'h0C, 8'h0D);
    step(); step();
    chk("mul2_c2_done", done_s, 0);
    step();
    chk("mul2_done", done_s, 1);
    chk("mul2_result", result_s, 16'h009C);
    start_s = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
